muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, runs a one-cycle multiply or a 32-iteration restoring divide, and drives the HI/LO write ports. It stalls the pipeline while a result is pending. It sits between EX and the `hilo` block; the `hilo` write-enable/data inputs connect directly to this block's outputs.

---
 rtl/muldiv_ctrl_pkg.sv | 26 ++
 rtl/div_core.sv | 90 +++++++++
 rtl/muldiv_ctrl.sv | 132 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states, reset level.
package muldiv_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/div_core.sv
// 32-iteration restoring divider on magnitudes; applies the sign fix-up on its outputs.
module div_core
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        run_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        a_neg, b_neg;
  logic [32:0] diff;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    a_neg  = signed_i & dividend_i[31];
    b_neg  = signed_i & divisor_i[31];
    // Partial remainder shifted left with the next dividend bit, minus the divisor.
    diff   = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    if (start_i) begin
      cnt_d = 5'd0;
      if (divisor_i == 32'd0) begin
        // Divide by zero: results are preloaded raw and never iterated.
        rem_d  = dividend_i;
        quo_d  = 32'hFFFF_FFFF;
        dvs_d  = 32'd0;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else begin
        rem_d  = 32'd0;
        quo_d  = a_neg ? -dividend_i : dividend_i;
        dvs_d  = b_neg ? -divisor_i : divisor_i;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
      end
    end else if (run_i) begin
      cnt_d = cnt_q + 5'd1;
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = {rem_q[30:0], quo_q[31]};
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  assign done_o      = run_i && (cnt_q == 5'd31);
  assign quotient_o  = qneg_q ? -quo_q : quo_q;
  assign remainder_o = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: one-cycle multiply, 32-cycle divide, MTHI/MTLO pass-through and EX stall.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hi_write_enable_o,
  output logic [31:0] hi_write_data_o,
  output logic        lo_write_enable_o,
  output logic [31:0] lo_write_data_o
);

  state_e      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        mul_signed_q, mul_signed_d;

  logic        accept;
  logic        is_div;
  logic        div_run;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [63:0] product;

  assign accept  = (state_q == ST_IDLE) && start_i && !flush_i && is_muldiv(op_i);
  assign is_div  = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
  assign div_run = (state_q == ST_DIV) && !flush_i;

  // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve MULT and MULTU.
  assign product = {{32{mul_signed_q & opa_q[31]}}, opa_q} *
                   {{32{mul_signed_q & opb_q[31]}}, opb_q};

  div_core u_div_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (accept && is_div),
    .run_i       (div_run),
    .signed_i    (op_i == MDU_DIV),
    .dividend_i  (opa_i),
    .divisor_i   (opb_i),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  always_comb begin
    state_d           = state_q;
    opa_d             = opa_q;
    opb_d             = opb_q;
    mul_signed_d      = mul_signed_q;
    stall_o           = accept;
    hi_write_enable_o = 1'b0;
    hi_write_data_o   = 32'd0;
    lo_write_enable_o = 1'b0;
    lo_write_data_o   = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opa_d        = opa_i;
          opb_d        = opb_i;
          mul_signed_d = (op_i == MDU_MULT);
          if (!is_div)              state_d = ST_MUL;
          else if (opb_i == 32'd0)  state_d = ST_FIX;
          else                      state_d = ST_DIV;
        end else if (start_i && !flush_i) begin
          if (op_i == MDU_MTHI) begin
            hi_write_enable_o = 1'b1;
            hi_write_data_o   = opa_i;
          end
          if (op_i == MDU_MTLO) begin
            lo_write_enable_o = 1'b1;
            lo_write_data_o   = opa_i;
          end
        end
      end
      ST_MUL: begin
        hi_write_enable_o = 1'b1;
        hi_write_data_o   = product[63:32];
        lo_write_enable_o = 1'b1;
        lo_write_data_o   = product[31:0];
        state_d           = ST_IDLE;
      end
      ST_DIV: begin
        stall_o = 1'b1;
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_write_enable_o = 1'b1;
        hi_write_data_o   = div_rem;
        lo_write_enable_o = 1'b1;
        lo_write_data_o   = div_quo;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush kills whatever is in flight, including the write of this cycle.
    if (flush_i) begin
      state_d           = ST_IDLE;
      hi_write_enable_o = 1'b0;
      hi_write_data_o   = 32'd0;
      lo_write_enable_o = 1'b0;
      lo_write_data_o   = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q      <= ST_IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      mul_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      mul_signed_q <= mul_signed_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, corner sequences, random vs model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] opa_i = 32'd0;
  logic [31:0] opb_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o;
  logic        hi_we, lo_we;
  logic [31:0] hi_wd, lo_wd;

  int vectors = 0;
  int miscompares = 0;

  muldiv_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .op_i              (op_i),
    .opa_i             (opa_i),
    .opb_i             (opb_i),
    .flush_i           (flush_i),
    .stall_o           (stall_o),
    .busy_o            (busy_o),
    .hi_write_enable_o (hi_we),
    .hi_write_data_o   (hi_wd),
    .lo_write_enable_o (lo_we),
    .lo_write_data_o   (lo_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    sa = a;
    sb = b;
    hi = 32'd0;
    lo = 32'd0;
    lat = 1;
    case (op)
      MDU_MULT: begin
        p  = longint'(sa) * longint'(sb);
        u  = p;
        hi = u[63:32];
        lo = u[31:0];
      end
      MDU_MULTU: begin
        u  = {32'd0, a} * {32'd0, b};
        hi = u[63:32];
        lo = u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lat = 33;
          if (op == MDU_DIVU) begin
            lo = a / b;
            hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
          end else begin
            lo = sa / sb;
            hi = sa % sb;
          end
        end
      end
      default: lat = 0;
    endcase
  endtask

  // Issue one op at T and follow it until both write strobes rise (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output logic [31:0] hi, output logic [31:0] lo,
                        output int stalls, output int cycles, output bit wrote,
                        output logic stall_w, output logic busy_w);
    @(negedge clk);
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    #1;
    stalls = 0; cycles = 0; wrote = 1'b0;
    hi = 32'd0; lo = 32'd0; stall_w = 1'b1; busy_w = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (hi_we && lo_we) begin
        hi = hi_wd; lo = lo_wd; stall_w = stall_o; busy_w = busy_o; wrote = 1'b1;
        break;
      end
      if (stall_o) stalls++;
      @(negedge clk);
      if (noise) begin
        start_i = 1'b1; op_i = MDU_MULT; opa_i = 32'd9; opb_i = 32'd9;
      end else begin
        start_i = 1'b0;
      end
      #1;
      cycles++;
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic verify(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit noise, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    logic [31:0] hi, lo;
    int          stalls, cycles;
    bit          wrote;
    logic        stall_w, busy_w;
    run_op(op, a, b, noise, hi, lo, stalls, cycles, wrote, stall_w, busy_w);
    check({name, " wrote"}, 64'(wrote), 64'd1);
    check({name, " hi"}, 64'(hi), 64'(exp_hi));
    check({name, " lo"}, 64'(lo), 64'(exp_lo));
    check({name, " latency"}, 64'(cycles), 64'(exp_lat));
    check({name, " stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check({name, " stall_at_write"}, 64'(stall_w), 64'd0);
    check({name, " busy_at_write"}, 64'(busy_w), 64'd1);
  endtask

  task automatic check_quiet(input string name);
    check({name, " stall"}, 64'(stall_o), 64'd0);
    check({name, " busy"}, 64'(busy_o), 64'd0);
    check({name, " we"}, 64'({hi_we, lo_we}), 64'd0);
    check({name, " data"}, {hi_wd, lo_wd}, 64'd0);
  endtask

  initial begin
    logic [31:0] mhi, mlo, ra, rb;
    logic [2:0]  rop;
    int          mlat, we_seen;

    vecs[0] = '{MDU_MULT,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[4] = '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[5] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[6] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[7] = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
    vecs[8] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd4,         32'hFFFF_FFFF, 32'hFFFF_FFF4, 1};

    #2;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++)
      verify($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
             vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // MTHI/MTLO write combinationally in IDLE without stalling.
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_MTHI; opa_i = 32'h1234; opb_i = 32'd0;
    #1;
    check("mthi we", 64'({hi_we, lo_we}), 64'b10);
    check("mthi data", 64'(hi_wd), 64'h1234);
    check("mthi stall", 64'(stall_o), 64'd0);
    op_i = MDU_MTLO; opa_i = 32'hCAFE_0001;
    #1;
    check("mtlo we", 64'({hi_we, lo_we}), 64'b01);
    check("mtlo data", 64'(lo_wd), 64'hCAFE_0001);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("mt no_state", 64'(busy_o), 64'd0);

    // start_i while dividing must not disturb the result.
    verify("div_ignore_start", MDU_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 33);

    // Flush mid-divide: no writes for the rest of the would-be operation.
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_DIVU; opa_i = 32'd100; opb_i = 32'd7;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush we", 64'({hi_we, lo_we}), 64'd0);
    we_seen = 0;
    for (int i = 11; i <= 33; i++) begin
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      if (hi_we || lo_we) we_seen++;
      if (i == 11) check("flush busy_after", 64'(busy_o), 64'd0);
    end
    check("flush no_write", 64'(we_seen), 64'd0);

    // Flush then immediate accept at T+11.
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_DIV; opa_i = 32'd50; opb_i = 32'd3;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b1; op_i = MDU_MULTU; opa_i = 32'd3; opb_i = 32'd5;
    #1;
    check("reaccept stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("reaccept we", 64'({hi_we, lo_we}), 64'b11);
    check("reaccept result", {hi_wd, lo_wd}, 64'd15);

    // Flush in the accept cycle cancels the start.
    @(negedge clk);
    flush_i = 1'b1; start_i = 1'b1; op_i = MDU_MULT; opa_i = 32'd2; opb_i = 32'd2;
    #1;
    check("flush_start stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    check("flush_start busy", 64'(busy_o), 64'd0);

    // Asynchronous reset at T+5 of a divide.
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_DIV; opa_i = 32'd1000; opb_i = 32'd9;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_quiet("midreset");
    @(negedge clk);
    rst = 1'b1;
    verify("after_reset", MDU_MULTU, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42, 1);

    // Random ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = ra & 32'h0000_FFFF; rb = rb & 32'h0000_00FF; end
        2: rb = -(rb & 32'h0000_00FF);
        default: ;
      endcase
      model(rop, ra, rb, mhi, mlo, mlat);
      verify($sformatf("rand%0d", n), rop, ra, rb, 1'b0, mhi, mlo, mlat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
